// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter
//   Two-requester arbiter in front of a single-ported data memory. r0 (CPU)
//   wins by default; r1 (loader) wins when it is the only requester or after
//   losing MAX_WAIT grants in a row. Each transaction takes three cycles:
//   grant (IDLE), memory access (ISSUE), completion (COMPLETE).
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   rN_req/we/addr/wdata    request and operands, held by the requester until rN_gnt
//   rN_gnt                  one-cycle accept pulse
//   rN_done                 one-cycle completion pulse
//   rN_rdata                read data, valid with rN_done on reads, held otherwise
//   m_addr/m_wdata/m_we/m_en  memory request, m_en high only in ISSUE
//   m_rdata                 memory read data, valid the cycle after m_en
module sc_dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_done,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_done,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    output logic          m_en,
    input  logic [DW-1:0] m_rdata
);

    localparam int unsigned WCW = ($clog2(MAX_WAIT + 1) < 2) ? 2 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] MAX_WAIT_W = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        COMPLETE = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic            owner_q, owner_d;     // 0 = r0, 1 = r1
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;

    logic            any_req;
    logic            pick_r1;

    always_comb begin
        any_req = r0_req | r1_req;
        pick_r1 = r1_req & (~r0_req | (wait_cnt_q == MAX_WAIT_W));
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = any_req ? ISSUE : IDLE;
            ISSUE:    state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Latched request, fairness counter and per-requester read data
    always_comb begin
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        if (state_q == IDLE) begin
            if (any_req) begin
                owner_d = pick_r1;
                we_d    = pick_r1 ? r1_we    : r0_we;
                addr_d  = pick_r1 ? r1_addr  : r0_addr;
                wdata_d = pick_r1 ? r1_wdata : r0_wdata;
            end
            if (!r1_req || pick_r1)
                wait_cnt_d = '0;
            else if (wait_cnt_q != MAX_WAIT_W)
                wait_cnt_d = wait_cnt_q + WCW'(1);
        end
        if (state_q == COMPLETE && !we_q) begin
            if (owner_q) rdata1_d = m_rdata;
            else         rdata0_d = m_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Outputs. Pulses are gated by reset so an in-flight transaction is
    // dropped in the reset cycle itself. Read data is bypassed from m_rdata
    // during COMPLETE so it is valid together with done; the registered copy
    // holds it afterwards.
    always_comb begin
        r0_gnt   = 1'b0;
        r1_gnt   = 1'b0;
        r0_done  = 1'b0;
        r1_done  = 1'b0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = addr_q;
        m_wdata  = wdata_q;
        r0_rdata = rdata0_q;
        r1_rdata = rdata1_q;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        r1_gnt = pick_r1;
                        r0_gnt = ~pick_r1;
                    end
                end
                ISSUE: begin
                    m_en = 1'b1;
                    m_we = we_q;
                end
                COMPLETE: begin
                    r1_done = owner_q;
                    r0_done = ~owner_q;
                    if (!we_q) begin
                        if (owner_q) r1_rdata = m_rdata;
                        else         r0_rdata = m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
